// File: rtl/oled_ctrl_seq.sv
// Power-up, init-ROM and frame-refresh sequencer for an SSD1331-class SPI OLED.
// Optional host command port enabled by defining OLED_CTRL_CMD_PORT_EN.
module oled_ctrl_seq #(
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 64,
  parameter int RESET_CYCLES = 250
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      frame_start_i,
  output logic [$clog2(WIDTH)-1:0]  pix_x_o,
  output logic [$clog2(HEIGHT)-1:0] pix_y_o,
  input  logic [15:0]               pix_color_i,
  output logic [7:0]                tx_data_o,
  output logic                      tx_dc_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic                      oled_res_n_o,
  output logic                      ready_o,
  output logic                      frame_done_o
`ifdef OLED_CTRL_CMD_PORT_EN
  ,
  input  logic                      cmd_valid_i,
  input  logic [7:0]                cmd_data_i,
  input  logic                      cmd_dc_i,
  output logic                      cmd_ready_o
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(RESET_CYCLES + 64);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] RMAX = CW'(RESET_CYCLES - 1);

  typedef enum logic [3:0] {
    RST_LO, RST_HI, INIT, IDLE, WIN, FETCH, HI, LO
`ifdef OLED_CTRL_CMD_PORT_EN
    , CMD
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            txValid_q, txValid_d;
  logic [7:0]      txData_q, txData_d;
  logic            txDc_q, txDc_d;
  logic            resN_q, resN_d;
  logic [XW-1:0]   pixX_q, pixX_d;
  logic [YW-1:0]   pixY_q, pixY_d;
  logic [15:0]     color_q, color_d;
  logic            pending_q, pending_d;
  logic            frameDone_q, frameDone_d;

  function automatic logic [7:0] romByte(input logic [5:0] i);
    case (i)
      6'd0:  romByte = 8'hAE; 6'd1:  romByte = 8'hA0; 6'd2:  romByte = 8'h72;
      6'd3:  romByte = 8'hA1; 6'd4:  romByte = 8'h00; 6'd5:  romByte = 8'hA2;
      6'd6:  romByte = 8'h00; 6'd7:  romByte = 8'hA4; 6'd8:  romByte = 8'hA8;
      6'd9:  romByte = 8'h3F; 6'd10: romByte = 8'hAD; 6'd11: romByte = 8'h8E;
      6'd12: romByte = 8'hB0; 6'd13: romByte = 8'h0B; 6'd14: romByte = 8'hB1;
      6'd15: romByte = 8'h31; 6'd16: romByte = 8'hB3; 6'd17: romByte = 8'hF0;
      6'd18: romByte = 8'h8A; 6'd19: romByte = 8'h64; 6'd20: romByte = 8'h8B;
      6'd21: romByte = 8'h78; 6'd22: romByte = 8'h8C; 6'd23: romByte = 8'h64;
      6'd24: romByte = 8'hBB; 6'd25: romByte = 8'h3A; 6'd26: romByte = 8'hBE;
      6'd27: romByte = 8'h3E; 6'd28: romByte = 8'h87; 6'd29: romByte = 8'h06;
      6'd30: romByte = 8'h81; 6'd31: romByte = 8'h91; 6'd32: romByte = 8'h82;
      6'd33: romByte = 8'h50; 6'd34: romByte = 8'h83; 6'd35: romByte = 8'h7D;
      6'd36: romByte = 8'hAF;
      default: romByte = 8'h00;
    endcase
  endfunction

  // Column window 0..WIDTH-1 then row window 0..HEIGHT-1.
  function automatic logic [7:0] winByte(input logic [2:0] i);
    case (i)
      3'd0:    winByte = 8'h15;
      3'd2:    winByte = 8'(WIDTH - 1);
      3'd3:    winByte = 8'h75;
      3'd5:    winByte = 8'(HEIGHT - 1);
      default: winByte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RST_LO;
      cnt_q       <= '0;
      txValid_q   <= 1'b0;
      txData_q    <= 8'h00;
      txDc_q      <= 1'b0;
      resN_q      <= 1'b0;
      pixX_q      <= '0;
      pixY_q      <= '0;
      color_q     <= 16'h0000;
      pending_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txValid_q   <= txValid_d;
      txData_q    <= txData_d;
      txDc_q      <= txDc_d;
      resN_q      <= resN_d;
      pixX_q      <= pixX_d;
      pixY_q      <= pixY_d;
      color_q     <= color_d;
      pending_q   <= pending_d;
      frameDone_q <= frameDone_d;
    end
  end

`ifdef OLED_CTRL_CMD_PORT_EN
  // A frame request arriving this very cycle already outranks the command port.
  assign cmd_ready_o = (state_q == IDLE) && !pending_q && !frame_start_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txValid_d   = txValid_q;
    txData_d    = txData_q;
    txDc_d      = txDc_q;
    resN_d      = resN_q;
    pixX_d      = pixX_q;
    pixY_d      = pixY_q;
    color_d     = color_q;
    pending_d   = pending_q;
    frameDone_d = 1'b0;
    if (frame_start_i && state_q != RST_LO && state_q != RST_HI) pending_d = 1'b1;
    // Byte states offer when idle and retire on handshake, so data holds while stalled.
    case (state_q)
      RST_LO: begin
        resN_d = 1'b0;
        if (cnt_q == RMAX) begin
          cnt_d   = '0;
          resN_d  = 1'b1;
          state_d = RST_HI;
        end else cnt_d = cnt_q + 1'b1;
      end
      RST_HI: begin
        if (cnt_q == RMAX) begin
          cnt_d   = '0;
          state_d = INIT;
        end else cnt_d = cnt_q + 1'b1;
      end
      INIT: begin
        if (!txValid_q) begin
          txValid_d = 1'b1;
          txData_d  = romByte(cnt_q[5:0]);
          txDc_d    = 1'b0;
        end else if (tx_ready_i) begin
          txValid_d = 1'b0;
          if (cnt_q == CW'(36)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (pending_q) begin
          pending_d = frame_start_i;
          cnt_d     = '0;
          state_d   = WIN;
        end
`ifdef OLED_CTRL_CMD_PORT_EN
        else if (cmd_valid_i && cmd_ready_o) begin
          txValid_d = 1'b1;
          txData_d  = cmd_data_i;
          txDc_d    = cmd_dc_i;
          state_d   = CMD;
        end
`endif
      end
      WIN: begin
        if (!txValid_q) begin
          txValid_d = 1'b1;
          txData_d  = winByte(cnt_q[2:0]);
          txDc_d    = 1'b0;
        end else if (tx_ready_i) begin
          txValid_d = 1'b0;
          if (cnt_q == CW'(5)) begin
            cnt_d   = '0;
            pixX_d  = '0;
            pixY_d  = '0;
            state_d = FETCH;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      FETCH: begin
        color_d = pix_color_i;
        state_d = HI;
      end
      HI: begin
        if (!txValid_q) begin
          txValid_d = 1'b1;
          txData_d  = color_q[15:8];
          txDc_d    = 1'b1;
        end else if (tx_ready_i) begin
          txValid_d = 1'b0;
          state_d   = LO;
        end
      end
      LO: begin
        if (!txValid_q) begin
          txValid_d = 1'b1;
          txData_d  = color_q[7:0];
          txDc_d    = 1'b1;
        end else if (tx_ready_i) begin
          txValid_d = 1'b0;
          state_d   = FETCH;
          if (pixX_q == XMAX) begin
            pixX_d = '0;
            if (pixY_q == YMAX) begin
              pixY_d      = '0;
              frameDone_d = 1'b1;
              state_d     = IDLE;
            end else pixY_d = pixY_q + 1'b1;
          end else pixX_d = pixX_q + 1'b1;
        end
      end
`ifdef OLED_CTRL_CMD_PORT_EN
      CMD: begin
        if (tx_ready_i) begin
          txValid_d = 1'b0;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = RST_LO;
    endcase
  end

  assign pix_x_o      = pixX_q;
  assign pix_y_o      = pixY_q;
  assign tx_data_o    = txData_q;
  assign tx_dc_o      = txDc_q;
  assign tx_valid_o   = txValid_q;
  assign oled_res_n_o = resN_q;
  assign ready_o      = (state_q == IDLE);
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_oled_ctrl_seq.sv
// Directed bench for oled_ctrl_seq on a 4x2 panel with 4-cycle reset phases.
module tb_oled_ctrl_seq;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int RC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frameStart = 1'b0;
  logic       txReady = 1'b1;
  logic [1:0] pixX;
  logic       pixY;
  logic [15:0] pixColor;
  logic [7:0] txData;
  logic       txDc, txValid, resN, ready, frameDone;
`ifdef OLED_CTRL_CMD_PORT_EN
  logic       cmdValid = 1'b0;
  logic [7:0] cmdData = 8'h00;
  logic       cmdDc = 1'b0;
  logic       cmdReady;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] txLog[$];
  int doneCount = 0;
  int sizeAtDone = -1;
  logic stallPrev = 1'b0;
  logic [8:0] stallByte = '0;
  logic [7:0] romExp[37] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
                             8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31,
                             8'hB3, 8'hF0, 8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64,
                             8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'h81, 8'h91,
                             8'h82, 8'h50, 8'h83, 8'h7D, 8'hAF};
  logic [7:0] winExp[6] = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01};

  assign pixColor = {5'b00000, pixY, pixX, 8'hA5};

  oled_ctrl_seq #(.WIDTH(W), .HEIGHT(H), .RESET_CYCLES(RC)) dut (
    .clock_i(clock),
    .reset_i(reset),
    .frame_start_i(frameStart),
    .pix_x_o(pixX),
    .pix_y_o(pixY),
    .pix_color_i(pixColor),
    .tx_data_o(txData),
    .tx_dc_o(txDc),
    .tx_valid_o(txValid),
    .tx_ready_i(txReady),
    .oled_res_n_o(resN),
    .ready_o(ready),
    .frame_done_o(frameDone)
`ifdef OLED_CTRL_CMD_PORT_EN
    ,
    .cmd_valid_i(cmdValid),
    .cmd_data_i(cmdData),
    .cmd_dc_i(cmdDc),
    .cmd_ready_o(cmdReady)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serializer model: logs transfers and checks that stalled bytes hold.
  always @(negedge clock) begin
    if (stallPrev) checkOutput("hold", {txValid, txDc, txData}, {1'b1, stallByte});
    stallPrev = txValid && !txReady && !reset;
    stallByte = {txDc, txData};
    if (txValid && txReady && !reset) txLog.push_back({txDc, txData});
    if (frameDone) begin
      doneCount++;
      sizeAtDone = txLog.size();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus();
    frameStart = 1'b1;
    tick(1);
    frameStart = 1'b0;
  endtask

  task automatic waitReady(input int bound, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (ready) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput(tag, 0, 1);
  endtask

  task automatic waitDone(input int d0, input int bound, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (doneCount > d0) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput(tag, 0, 1);
  endtask

  task automatic checkRom(input int base, input string tag);
    int bad = 0;
    for (int k = 0; k < 37; k++)
      if (base + k < txLog.size() && txLog[base+k] !== {1'b0, romExp[k]}) bad++;
    checkOutput(tag, bad, 0);
  endtask

  task automatic checkFrame(input int base, input string tag);
    int bad = 0;
    logic [8:0] exp;
    for (int k = 0; k < 22; k++) begin
      if (k < 6) exp = {1'b0, winExp[k]};
      else if (((k - 6) % 2) == 0) exp = {1'b1, 8'((k - 6) / 2)};
      else exp = {1'b1, 8'hA5};
      if (base + k >= txLog.size() || txLog[base+k] !== exp) bad++;
    end
    checkOutput(tag, bad, 0);
  endtask

  task automatic countResetLow(input string tag);
    int lowCnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (resN) break;
      lowCnt++;
    end
    checkOutput(tag, lowCnt, RC);
    tick(1);
  endtask

  initial begin
    int d0;
    int pixBytes;
    bit hit;
    tick(3);
    checkOutput("rst_valid", txValid, 0);
    checkOutput("rst_resn", resN, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_data", {txDc, txData}, 0);
    checkOutput("rst_pix", {pixY, pixX}, 0);
    checkOutput("rst_done", frameDone, 0);

    reset = 1'b0;
    countResetLow("res_low_cycles");
    waitReady(2000, "init_timeout");
    checkOutput("rom_len", txLog.size(), 37);
    checkOutput("rom_first", txLog[0], {1'b0, 8'hAE});
    checkOutput("rom_last", txLog[36], {1'b0, 8'hAF});
    checkRom(0, "rom_bytes");
    checkOutput("ready_after_init", ready, 1);

    txLog.delete();
    d0 = doneCount;
    applyStimulus();
    waitDone(d0, 500, "frame1_timeout");
    checkOutput("done_pos", sizeAtDone, 22);
    tick(5);
    checkOutput("frame1_len", txLog.size(), 22);
    checkFrame(0, "frame1_bytes");
    checkOutput("frame1_done_once", doneCount - d0, 1);
    checkOutput("ready_after_frame", ready, 1);

    txLog.delete();
    d0 = doneCount;
    applyStimulus();
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (txValid && txDc && txLog.size() == 10) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput("stall_timeout", 0, 1);
    txReady = 1'b0;
    tick(5);
    checkOutput("stall_valid", txValid, 1);
    checkOutput("stall_byte", {txDc, txData}, {1'b1, 8'h02});
    txReady = 1'b1;
    waitDone(d0, 500, "frame2_timeout");
    tick(5);
    checkOutput("stall_len", txLog.size(), 22);
    checkFrame(0, "stall_bytes");

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    txLog.delete();
    d0 = doneCount;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (txValid) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput("init2_timeout", 0, 1);
    applyStimulus();
    tick(2);
    applyStimulus();
    tick(2);
    applyStimulus();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (txValid && txDc) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput("pixel_timeout", 0, 1);
    applyStimulus();
    tick(3);
    applyStimulus();
    tick(600);
    checkOutput("pending_frames", doneCount - d0, 2);
    checkOutput("pending_len", txLog.size(), 37 + 44);
    checkRom(0, "pending_rom");
    checkFrame(37, "pending_frame_a");
    checkFrame(59, "pending_frame_b");
    checkOutput("pending_idle", ready, 1);

    txLog.delete();
    d0 = doneCount;
    applyStimulus();
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (txLog.size() == 15) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    if (!hit) checkOutput("midreset_timeout", 0, 1);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_valid", txValid, 0);
    checkOutput("midreset_resn", resN, 0);
    txLog.delete();
    reset = 1'b0;
    applyStimulus();
    tick(600);
    pixBytes = 0;
    foreach (txLog[k]) if (txLog[k][8]) pixBytes++;
    checkOutput("replay_len", txLog.size(), 37);
    checkRom(0, "replay_rom");
    checkOutput("replay_no_pixels", pixBytes, 0);
    checkOutput("replay_no_done", doneCount - d0, 0);
    checkOutput("replay_ready", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
